alu_instruction_decoder: RTL and testbench

- Producer side of the ALU operation interface: accepts raw 32-bit RV32I instruction words over a valid/ready handshake and decodes OP and OP-IMM instructions.
- Emits registered ALU control and operand-select fields (funct3, funct7, opImm, immediateI) plus register addresses, with an illegal flag and a decoded-instruction counter.
- Sits between fetch and the register-file/ALU stage.

---
 rtl/alu_instruction_decoder.sv | 155 +++++++++++++++
 tb/tb_alu_instruction_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_instruction_decoder.sv
// RV32I OP / OP-IMM decoder with valid/ready handshake on both sides and a saturating legal-decode counter.
// Define ALU_DECODER_SKID_EN for a two-entry (output + skid) buffer with a registered instr_ready.
module alu_instruction_decoder #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [31:0]            instruction,
    output logic                   dec_valid,
    input  logic                   dec_ready,
    output logic [2:0]             funct3,
    output logic [6:0]             funct7,
    output logic                   opImm,
    output logic [31:0]            immediateI,
    output logic [4:0]             rs1Addr,
    output logic [4:0]             rs2Addr,
    output logic [4:0]             rdAddr,
    output logic                   illegal,
    output logic [COUNT_WIDTH-1:0] decodedCount
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        op_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } dec_t;

    // Non-OP opcodes keep the OP field layout and are flagged illegal.
    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d.funct3  = w[14:12];
        d.funct7  = w[31:25];
        d.op_imm  = 1'b0;
        d.imm     = '0;
        d.rs1     = w[19:15];
        d.rs2     = w[24:20];
        d.rd      = w[11:7];
        d.illegal = 1'b1;
        case (w[6:0])
            OPC_OP: begin
                d.illegal = !((d.funct7 == F7_ZERO) ||
                              ((d.funct7 == F7_ALT) &&
                               ((d.funct3 == 3'b000) || (d.funct3 == 3'b101))));
            end
            OPC_OPIMM: begin
                d.op_imm = 1'b1;
                d.imm    = {{20{w[31]}}, w[31:20]};
                case (d.funct3)
                    3'b001:  d.illegal = (d.funct7 != F7_ZERO);
                    3'b101:  d.illegal = !((d.funct7 == F7_ZERO) || (d.funct7 == F7_ALT));
                    default: begin
                        d.funct7  = F7_ZERO;
                        d.illegal = 1'b0;
                    end
                endcase
            end
            default: ;
        endcase
        return d;
    endfunction

    dec_t in_dec;
    dec_t out_q;
    logic out_v;
    logic in_fire;
    logic out_fire;

    assign in_dec   = decode(instruction);
    assign in_fire  = instr_valid && instr_ready;
    assign out_fire = out_v && dec_ready;

`ifdef ALU_DECODER_SKID_EN
    dec_t skid_q;
    logic skid_v;

    // Ready comes straight from a flop, so dec_ready never reaches instr_ready.
    assign instr_ready = !skid_v;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q  <= '0;
            out_v  <= 1'b0;
            skid_q <= '0;
            skid_v <= 1'b0;
        end else if (flush) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (!out_v || dec_ready) begin
            // in_fire and skid_v are mutually exclusive, so order is preserved.
            if (skid_v) begin
                out_q  <= skid_q;
                out_v  <= 1'b1;
                skid_v <= 1'b0;
            end else if (in_fire) begin
                out_q <= in_dec;
                out_v <= 1'b1;
            end else begin
                out_v <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q <= in_dec;
            skid_v <= 1'b1;
        end
    end
`else
    assign instr_ready = !out_v || dec_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_q <= '0;
            out_v <= 1'b0;
        end else if (flush) begin
            out_v <= 1'b0;
        end else if (in_fire) begin
            out_q <= in_dec;
            out_v <= 1'b1;
        end else if (out_fire) begin
            out_v <= 1'b0;
        end
    end
`endif

    // Counts handoffs of legal entries, including one that leaves on a flush edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            decodedCount <= '0;
        end else if (out_fire && !out_q.illegal && (decodedCount != {COUNT_WIDTH{1'b1}})) begin
            decodedCount <= decodedCount + COUNT_WIDTH'(1);
        end
    end

    assign dec_valid  = out_v;
    assign funct3     = out_q.funct3;
    assign funct7     = out_q.funct7;
    assign opImm      = out_q.op_imm;
    assign immediateI = out_q.imm;
    assign rs1Addr    = out_q.rs1;
    assign rs2Addr    = out_q.rs2;
    assign rdAddr     = out_q.rd;
    assign illegal    = out_q.illegal;

endmodule

// File: tb/tb_alu_instruction_decoder.sv
// Directed bench for alu_instruction_decoder with a scoreboard of reference decodes.
module tb_alu_instruction_decoder;

    localparam int CW   = 2;
    localparam int MAXC = (1 << CW) - 1;
`ifdef ALU_DECODER_SKID_EN
    localparam int EXP_ACC = 2;
`else
    localparam int EXP_ACC = 1;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          flush = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [31:0]   instruction = '0;
    logic          dec_valid;
    logic          dec_ready = 1'b0;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic          opImm;
    logic [31:0]   immediateI;
    logic [4:0]    rs1Addr, rs2Addr, rdAddr;
    logic          illegal;
    logic [CW-1:0] decodedCount;

    int vectors = 0;
    int errors  = 0;
    int exp_cnt = 0;
    int out_seen = 0;
    logic [58:0] sb[$];
    logic [58:0] got;
    logic [58:0] last_got;
    logic        last_stall = 1'b0;

    always #5 clock = ~clock;

    alu_instruction_decoder #(.COUNT_WIDTH(CW)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .funct3(funct3), .funct7(funct7), .opImm(opImm), .immediateI(immediateI),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr), .rdAddr(rdAddr),
        .illegal(illegal), .decodedCount(decodedCount)
    );

    assign got = {funct3, funct7, opImm, immediateI, rs1Addr, rs2Addr, rdAddr, illegal};

    // Reference decode: {funct3, funct7, opImm, imm, rs1, rs2, rd, illegal}
    function automatic logic [58:0] ref_dec(input logic [31:0] w);
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        oi;
        logic [31:0] im;
        logic        il;
        f3 = w[14:12];
        f7 = w[31:25];
        oi = 1'b0;
        im = 32'h0;
        if (w[6:0] == 7'h33) begin
            il = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        end else if (w[6:0] == 7'h13) begin
            oi = 1'b1;
            im = w[31] ? {20'hFFFFF, w[31:20]} : {20'h0, w[31:20]};
            if (f3 == 3'd1)      il = (f7 != 7'h00);
            else if (f3 == 3'd5) il = !(f7 == 7'h00 || f7 == 7'h20);
            else begin
                f7 = 7'h00;
                il = 1'b0;
            end
        end else begin
            il = 1'b1;
        end
        return {f3, f7, oi, im, w[19:15], w[24:20], w[11:7], il};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard/monitor, sampled on the falling edge while inputs are stable.
    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
            exp_cnt = 0;
            last_stall = 1'b0;
        end else begin
            chk("count", 64'(decodedCount), 64'(exp_cnt));
            if (last_stall && dec_valid) chk("stable", 64'(got), 64'(last_got));
            if (dec_valid && dec_ready) begin
                out_seen++;
                if (sb.size() == 0) chk("sb_depth", 64'(sb.size()), 64'd1);
                else chk("entry", 64'(got), 64'(sb.pop_front()));
                if (!illegal && exp_cnt < MAXC) exp_cnt++;
            end
            if (flush) sb.delete();
            else if (instr_valid && instr_ready) sb.push_back(ref_dec(instruction));
            last_stall = dec_valid && !dec_ready;
            last_got   = got;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Returns at posedge+1 of the edge that accepted the word.
    task automatic send(input logic [31:0] w);
        int n;
        n = 0;
        instr_valid = 1'b1;
        instruction = w;
        forever begin
            @(negedge clock);
            if (instr_ready || n > 40) break;
            n++;
        end
        chk("send_ready", 64'(instr_ready), 64'd1);
        tick();
        instr_valid = 1'b0;
    endtask

    logic [31:0] bp_w[3];
    int acc;
    int base;

    initial begin
        bp_w[0] = 32'h00208033;
        bp_w[1] = 32'h00310113;
        bp_w[2] = 32'h40315093;

        #12;
        chk("reset_state", 64'({dec_valid, instr_ready, got, decodedCount}), 64'({1'b0, 1'b1, 59'h0, 2'd0}));
        tick();
        reset = 1'b0;
        dec_ready = 1'b1;

        send(32'hFFF10093);
        chk("addi", 64'({dec_valid, opImm, funct3, funct7, rs1Addr, rdAddr, immediateI, illegal}),
            64'({1'b1, 1'b1, 3'b000, 7'h00, 5'd2, 5'd1, 32'hFFFFFFFF, 1'b0}));
        chk("addi_cnt0", 64'(decodedCount), 64'd0);
        tick();
        chk("addi_cnt1", 64'(decodedCount), 64'd1);

        send(32'h00002003);
        chk("lw_illegal", 64'({dec_valid, illegal}), 64'({1'b1, 1'b1}));
        send(32'h40009093);
        chk("slli_illegal", 64'({dec_valid, illegal, funct7}), 64'({1'b1, 1'b1, 7'h20}));
        tick();
        chk("illegal_cnt", 64'(decodedCount), 64'd1);

        send(32'h402081B3);
        chk("sub", 64'({dec_valid, opImm, funct3, funct7, rs1Addr, rs2Addr, rdAddr, immediateI, illegal}),
            64'({1'b1, 1'b0, 3'b000, 7'h20, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0}));
        send(32'h40335293);
        chk("srai", 64'({dec_valid, opImm, funct3, funct7, immediateI, illegal}),
            64'({1'b1, 1'b1, 3'b101, 7'h20, 32'h00000403, 1'b0}));
        tick();
        tick();
        chk("cnt_sat", 64'(decodedCount), 64'(MAXC));

        // Backpressure: three words offered while the consumer stalls.
        dec_ready = 1'b0;
        base = out_seen;
        acc = 0;
        instr_valid = 1'b1;
        instruction = bp_w[0];
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            if (instr_ready) acc++;
            tick();
            if (acc < 3) instruction = bp_w[acc];
        end
        chk("bp_accepted", 64'(acc), 64'(EXP_ACC));
        chk("bp_ready_low", 64'(instr_ready), 64'd0);
        dec_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 3; c++) begin
            @(negedge clock);
            if (instr_ready) acc++;
            tick();
            if (acc < 3) instruction = bp_w[acc];
            else instr_valid = 1'b0;
        end
        instr_valid = 1'b0;
        repeat (4) tick();
        chk("bp_out_count", 64'(out_seen - base), 64'd3);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);
        chk("bp_cnt_sat", 64'(decodedCount), 64'(MAXC));

        // Flush with one entry buffered.
        dec_ready = 1'b0;
        send(32'h00520213);
        chk("pre_flush_valid", 64'(dec_valid), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_valid", 64'(dec_valid), 64'd0);
        chk("flush_cnt", 64'(decodedCount), 64'(MAXC));
        tick();
        chk("flush_still_empty", 64'(dec_valid), 64'd0);

        // Asynchronous reset mid-stream.
        send(32'h00730313);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset", 64'({dec_valid, instr_ready, got, decodedCount}), 64'({1'b0, 1'b1, 59'h0, 2'd0}));
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_sb", 64'(sb.size()), 64'd0);
        chk("post_reset_cnt", 64'(decodedCount), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
